// File: rtl/mem_port_arbiter.sv
// Three-port arbiter (debug > data > fetch) in front of a single-ported,
// fixed-latency unified memory; every access is a stall-until-ack transaction.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    input  logic          g_req,
    input  logic          g_we,
    input  logic [AW-1:0] g_addr,
    input  logic [DW-1:0] g_wdata,
    output logic          g_ack,
    output logic [DW-1:0] g_rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_G    = 2'd3;

    state_e        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [DW-1:0] g_rdata_q, g_rdata_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            g_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            g_rdata_q <= g_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req || d_req || g_req) state_d = ACCESS;
            ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        g_rdata_d = g_rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = CNT_INIT;
                if (g_req) begin
                    owner_d = OWN_G;
                    we_d    = g_we;
                    addr_d  = g_addr;
                    wdata_d = g_wdata;
                end else if (d_req) begin
                    owner_d = OWN_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end else if (i_req) begin
                    owner_d = OWN_I;
                    we_d    = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = '0;
                end else begin
                    owner_d = OWN_NONE;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // writes leave the owner's read data untouched
                    if (!we_q) begin
                        case (owner_q)
                            OWN_I:   i_rdata_d = mem_rdata;
                            OWN_D:   d_rdata_d = mem_rdata;
                            OWN_G:   g_rdata_d = mem_rdata;
                            default: ;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    owner_d = OWN_NONE;
            default: owner_d = OWN_NONE;
        endcase
    end

    always_comb begin
        mem_cs    = (state_q == ACCESS);
        mem_we    = mem_cs && we_q && (owner_q != OWN_I);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        busy      = (state_q != IDLE);
        owner     = owner_q;
        i_ack     = (state_q == DONE) && (owner_q == OWN_I);
        d_ack     = (state_q == DONE) && (owner_q == OWN_D);
        g_ack     = (state_q == DONE) && (owner_q == OWN_G);
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
        g_rdata   = g_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
// Inputs change and outputs are checked on the falling clock edge.
module tb_mem_port_arbiter;

    localparam int W = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        g_req = 1'b0;
    logic        g_we = 1'b0;
    logic [31:0] g_addr = '0;
    logic [31:0] g_wdata = '0;
    logic        g_ack;
    logic [31:0] g_rdata;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  owner;

    logic [31:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_a = '0;
    logic [31:0] pre_d = '0;
    logic [2:0]  acks;

    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_cs && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    assign mem_rdata = mem[mem_addr[7:2]];
    assign acks = {g_ack, d_ack, i_ack};

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_ack(g_ack), .g_rdata(g_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %h, exp %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        pre_we = 1'b1;
        pre_a  = a[7:2];
        pre_d  = d;
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    // Call right after raising req(s) on a falling edge while idle.
    // mode 1: drop all reqs after the first mem_cs cycle.
    // mode 2: scramble the data port inputs after the first mem_cs cycle.
    task automatic run_acc(input logic [1:0] own, input logic we,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int mode);
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge CLK);
            if (c <= W) begin
                chk("cs", 32'(mem_cs), 32'd1);
                chk("owner", 32'(owner), 32'(own));
                chk("we", 32'(mem_we), 32'(we));
                chk("addr", mem_addr, a);
                if (we) chk("wdata", mem_wdata, wd);
                chk("ack_idle", 32'(acks), 32'd0);
                chk("busy", 32'(busy), 32'd1);
            end else begin
                chk("cs_done", 32'(mem_cs), 32'd0);
                chk("ack", 32'(acks), 32'd1 << (own - 2'd1));
                chk("owner_done", 32'(owner), 32'(own));
            end
            if (c == 1 && mode == 1) begin
                i_req = 1'b0;
                d_req = 1'b0;
                g_req = 1'b0;
            end
            if (c == 1 && mode == 2) begin
                d_addr  = 32'h30;
                d_wdata = 32'h0;
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        @(negedge CLK);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
        chk({tag, "_cs"}, 32'(mem_cs), 32'd0);
        chk({tag, "_ack"}, 32'(acks), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge CLK);
        chk("rst_cs", 32'(mem_cs), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_acks", 32'(acks), 32'd0);
        chk("rst_drd", d_rdata, 32'd0);
        nRST = 1'b1;
        preload(32'h10, 32'h2008_0005);
        preload(32'h20, 32'h1111_1111);
        preload(32'h24, 32'h2222_2222);

        // single fetch
        chk_idle("t1_pre");
        i_req = 1'b1; i_addr = 32'h10;
        run_acc(2'd1, 1'b0, 32'h10, 32'h0, 0);
        chk("t1_rdata", i_rdata, 32'h2008_0005);
        i_req = 1'b0;
        chk_idle("t1_post");
        chk_idle("t1_post2");

        // store then load, inputs scrambled mid-access
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
        run_acc(2'd2, 1'b1, 32'h8, 32'hDEAD_BEEF, 2);
        chk("t2_wr_rdata", d_rdata, 32'h0);
        d_req = 1'b0;
        chk_idle("t2_mid");
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        run_acc(2'd2, 1'b0, 32'h8, 32'h0, 0);
        chk("t2_rd_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("t2_i_kept", i_rdata, 32'h2008_0005);
        d_req = 1'b0;
        chk_idle("t2_post");

        // simultaneous requests: G, then D, then I
        g_req = 1'b1; g_we = 1'b0; g_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        i_req = 1'b1; i_addr = 32'h24;
        run_acc(2'd3, 1'b0, 32'h20, 32'h0, 0);
        chk("t3_grd", g_rdata, 32'h1111_1111);
        g_req = 1'b0;
        chk_idle("t3_gap1");
        run_acc(2'd2, 1'b0, 32'h8, 32'h0, 0);
        chk("t3_drd", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        chk_idle("t3_gap2");
        run_acc(2'd1, 1'b0, 32'h24, 32'h0, 0);
        chk("t3_ird", i_rdata, 32'h2222_2222);
        i_req = 1'b0;
        chk_idle("t3_post");

        // reset pulsed during a data read
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        @(negedge CLK);
        chk("t4_cs", 32'(mem_cs), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("t4_async_cs", 32'(mem_cs), 32'd0);
        chk("t4_async_busy", 32'(busy), 32'd0);
        chk("t4_async_owner", 32'(owner), 32'd0);
        chk("t4_async_drd", d_rdata, 32'd0);
        @(negedge CLK);
        chk("t4_no_ack", 32'(acks), 32'd0);
        nRST = 1'b1;
        run_acc(2'd2, 1'b0, 32'h8, 32'h0, 0);
        chk("t4_drd", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        chk_idle("t4_post");

        // fetch request withdrawn mid-access
        i_req = 1'b1; i_addr = 32'h10;
        run_acc(2'd1, 1'b0, 32'h10, 32'h0, 1);
        chk("t5_rdata", i_rdata, 32'h2008_0005);
        chk_idle("t5_post");
        chk_idle("t5_post2");

        // fetch request held across ack -> back-to-back fetches
        i_req = 1'b1; i_addr = 32'h24;
        run_acc(2'd1, 1'b0, 32'h24, 32'h0, 0);
        chk("t6_rd1", i_rdata, 32'h2222_2222);
        i_addr = 32'h10;
        chk_idle("t6_gap");
        run_acc(2'd1, 1'b0, 32'h10, 32'h0, 0);
        chk("t6_rd2", i_rdata, 32'h2008_0005);
        i_req = 1'b0;
        chk_idle("t6_post");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
